key_event_queue: RTL and testbench
==================================

# key_event_queue

Downstream consumer of the push-button debouncer. Turns its level outputs (`data_tecla` key code, `irq_pin` key-active) into discrete press, repeat and release events. Buffers the events in a small FIFO and presents them to the processor over the asynchronous chip-select read bus. A level interrupt stays high while events are pending, so no keystroke is lost between CPU service intervals.

## Interface
- `DEPTH`, 8: FIFO entries; legal values 2, 4, 8.
- `REPEAT_DELAY`, 20000000: cycles a key must be held before the first repeat event.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeat events.
- `CNTW`, 25: repeat counter width; must hold `REPEAT_DELAY`.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `key_code`  in  8  debounced key code (`data_tecla`); holds the last code after release.
- `key_act`  in  1  high while any debounced input is active (`irq_pin`).
- `nCS`  in  1  bus chip select, active-low, asynchronous to `clk`.
- `nRD`  in  1  bus read strobe, active-low, asynchronous.
- `addr`  in  1  0 = event data, 1 = status.
- `rdata`  out  8  read data, registered.
- `irq`  out  1  high while the FIFO is non-empty, registered.

## Operation
- **Input stage.** `key_act` is registered into `act_q`, then `act_q2`. `key_code` is sampled in the cycle where `act_q` is valid, because the debouncer's code register lags `key_act` by one cycle.
- **Press.** `act_q & ~act_q2` pushes `{rel=0, key_code}`, latches `held_code` and loads the repeat counter with `REPEAT_DELAY`.
- **Key change while held.** `act_q & act_q2 & key_code != held_code` pushes a press of the new code, updates `held_code` and reloads `REPEAT_DELAY`. No release event is pushed for the old code.
- **Repeat.** While `act_q` is high, the counter decrements each cycle. When it reaches 1, a repeat event (identical to a press, `{0, held_code}`) is pushed and the counter reloads `REPEAT_RATE`.
- **Release.** `~act_q & act_q2` pushes `{rel=1, held_code}` and stops the counter.
- **Entries.** Each FIFO entry is 9 bits: `{rel, code[7:0]}`.
- **Bus synchronisation.** `nCS`, `nRD` and `addr` each pass through a 2-flop synchroniser. A read is the synchronised `nRD` low while synchronised `nCS` is low.
- **Read data.** During a read, `rdata` is the head code when `addr=0`, or the status byte when `addr=1`. `rdata` is 0x00 outside a read.
- **Status byte.**
  - bit7 = sticky overflow
  - bit6 = head `rel`
  - bit5 = full
  - bit4 = empty
  - bits3:0 = entry count (0..8)
- **Read completion** is the synchronised `nRD` rising edge with `nCS` still low.
  - With `addr=0`, the head is popped; completion while empty has no effect.
  - With `addr=1`, overflow is cleared.
- **Full FIFO.** A push into a full FIFO is dropped and sets overflow. A push and a pop in the same cycle while full both succeed.
- **Empty FIFO.** A data read while empty returns 0x00 and pops nothing. A push and a pop in the same cycle while empty: the push succeeds and the pop is ignored.
- **Event priority.** At most one event is generated per cycle, in this order: release, key change, press, repeat.
- **Reset.** Asserting `reset` clears the FIFO, pointers, overflow, counters, synchronisers, `held_code`, `act_q` and `act_q2`. `rdata=0x00` and `irq=0`. This applies mid-hold and mid-read alike.

## Timing
- If `key_act` is first sampled high at edge N, the press entry is written at edge N+2 and `irq` rises after edge N+3.
- First repeat: `REPEAT_DELAY` cycles after the press push. Subsequent repeats: every `REPEAT_RATE` cycles.
- Bus latency: 2 synchroniser cycles plus 1 register cycle from a pin change to `rdata` valid. The CPU holds `nRD` low for at least 4 `clk` cycles.
- Pop happens 3 cycles after `nRD` rises. `irq` falls 1 cycle after the last pop.
- The status count reflects the FIFO state one cycle earlier.

## Structure
- Package `key_pkg` holds:
  - status bit positions (`ST_OVF`, `ST_REL`, `ST_FULL`, `ST_EMPTY`, count field);
  - the entry width constant (9);
  - address decode constants (`A_DATA=0`, `A_STAT=1`).
- Sub-module `key_fifo`: a synchronous circular FIFO with parameterised depth, push/pop, full/empty/count outputs and head data. It is reused for any future input queue.

## Test plan
- **Single press/release.** Press code 202, hold 10 cycles, release, then two data reads with status checks. Required: status reads count=2; reads return 202 with rel=0, then 202 with rel=1; `irq` falls after the second pop.
- **Auto-repeat.** With `REPEAT_DELAY=20` and `REPEAT_RATE=5`, hold code 86 for 36 cycles. Required: press, then repeats at +20, +25, +30, +35, then release; 6 entries total.
- **Key change.** Code 75 held, then code changes to 232 while active. Required: press 75, press 232; the release carries 232.
- **Overflow.** With `DEPTH=8`, push 9 events. Required: status reads 0xA8 (overflow, full, count=8), 9th event dropped; a status read clears bit7.
- **Empty read.** Data read with the FIFO empty. Required: `rdata=0x00`, count stays 0, no underflow.
- **Async reset mid-hold.** Assert `reset` while a key is held with 3 entries queued. Required: `irq=0` and count=0 immediately. After deassertion with the key still held, a fresh press event is pushed.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the key event queue.
// Holds the status byte layout, the entry format and the bus address decode.
package key_pkg;

   localparam int CODE_W  = 8;
   localparam int ENTRY_W = CODE_W + 1;

   localparam int ST_OVF     = 7;
   localparam int ST_REL     = 6;
   localparam int ST_FULL    = 5;
   localparam int ST_EMPTY   = 4;
   localparam int ST_CNT_MSB = 3;
   localparam int ST_CNT_LSB = 0;

   localparam logic A_DATA = 1'b0;
   localparam logic A_STAT = 1'b1;

   typedef struct packed {
      logic              rel;
      logic [CODE_W-1:0] code;
   } key_entry_t;

   function automatic logic [7:0] pack_status(input logic       ovf,
                                              input logic       rel,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [3:0] cnt);
      logic [7:0] s;
      s                        = '0;
      s[ST_OVF]                = ovf;
      s[ST_REL]                = rel;
      s[ST_FULL]               = full;
      s[ST_EMPTY]              = empty;
      s[ST_CNT_MSB:ST_CNT_LSB] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous circular FIFO with push/pop, full/empty/count and head data.
// DEPTH must be a power of two so the pointers wrap naturally.
module key_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [W-1:0]               i_wdata,
   input  logic                       i_pop,
   output logic [W-1:0]               o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop & ~o_empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_drop    = i_push & ~w_push_ok;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into press/repeat/release events, queues them,
// and serves them over an asynchronous chip-select read bus with a level irq.
module key_event_queue
   import key_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int REPEAT_DELAY = 20000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int CNTW         = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CODE_W-1:0] key_code,
   input  logic              key_act,
   input  logic              nCS,
   input  logic              nRD,
   input  logic              addr,
   output logic [7:0]        rdata,
   output logic              irq
);

   localparam int CW = $clog2(DEPTH+1);

   logic              r_act_q;
   logic              r_act_q2;
   logic [CODE_W-1:0] r_held_code;
   logic [CNTW-1:0]   r_rep_cnt;
   logic              r_rep_run;
   logic              r_ev_vld;
   key_entry_t        r_ev;

   logic r_ncs_s1, r_ncs_s2;
   logic r_nrd_s1, r_nrd_s2, r_nrd_s3;
   logic r_addr_s1, r_addr_s2;
   logic r_done_data, r_done_stat;
   logic r_ovf;

   logic          w_release, w_change, w_press, w_repeat;
   logic          w_rd, w_done;
   logic          w_full, w_empty, w_drop;
   logic [CW-1:0] w_count;
   key_entry_t    w_head;
   logic [7:0]    w_status;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_act_q  <= 1'b0;
         r_act_q2 <= 1'b0;
      end else begin
         r_act_q  <= key_act;
         r_act_q2 <= r_act_q;
      end
   end

   // The debouncer's code register lags key_act by one cycle, so key_code is
   // only trusted while r_act_q is high.
   assign w_release = ~r_act_q & r_act_q2;
   assign w_change  = r_act_q & r_act_q2 & (key_code != r_held_code);
   assign w_press   = r_act_q & ~r_act_q2;
   assign w_repeat  = r_act_q & r_act_q2 & r_rep_run & (r_rep_cnt == CNTW'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ev_vld    <= 1'b0;
         r_ev        <= '0;
         r_held_code <= '0;
         r_rep_cnt   <= '0;
         r_rep_run   <= 1'b0;
      end else begin
         r_ev_vld <= 1'b0;
         if (w_release) begin
            r_ev_vld  <= 1'b1;
            r_ev      <= {1'b1, r_held_code};
            r_rep_run <= 1'b0;
         end else if (w_change || w_press) begin
            r_ev_vld    <= 1'b1;
            r_ev        <= {1'b0, key_code};
            r_held_code <= key_code;
            r_rep_cnt   <= CNTW'(REPEAT_DELAY);
            r_rep_run   <= 1'b1;
         end else if (w_repeat) begin
            r_ev_vld  <= 1'b1;
            r_ev      <= {1'b0, r_held_code};
            r_rep_cnt <= CNTW'(REPEAT_RATE);
         end else if (r_act_q && r_rep_run) begin
            r_rep_cnt <= r_rep_cnt - 1'b1;
         end
      end
   end

   key_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_ev_vld),
      .i_wdata (r_ev),
      .i_pop   (r_done_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_drop  (w_drop)
   );

   // Strobe synchronisers reset to their idle (high) level so no phantom
   // read or completion is seen as reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ncs_s1  <= 1'b1;
         r_ncs_s2  <= 1'b1;
         r_nrd_s1  <= 1'b1;
         r_nrd_s2  <= 1'b1;
         r_nrd_s3  <= 1'b1;
         r_addr_s1 <= 1'b0;
         r_addr_s2 <= 1'b0;
      end else begin
         r_ncs_s1  <= nCS;
         r_ncs_s2  <= r_ncs_s1;
         r_nrd_s1  <= nRD;
         r_nrd_s2  <= r_nrd_s1;
         r_nrd_s3  <= r_nrd_s2;
         r_addr_s1 <= addr;
         r_addr_s2 <= r_addr_s1;
      end
   end

   assign w_rd     = ~r_nrd_s2 & ~r_ncs_s2;
   assign w_done   = r_nrd_s2 & ~r_nrd_s3 & ~r_ncs_s2;
   assign w_status = pack_status(r_ovf, w_head.rel & ~w_empty, w_full, w_empty, 4'(w_count));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done_data <= 1'b0;
         r_done_stat <= 1'b0;
         r_ovf       <= 1'b0;
         irq         <= 1'b0;
         rdata       <= '0;
      end else begin
         r_done_data <= w_done & (r_addr_s2 == A_DATA);
         r_done_stat <= w_done & (r_addr_s2 == A_STAT);
         if (w_drop)           r_ovf <= 1'b1;
         else if (r_done_stat) r_ovf <= 1'b0;
         irq <= ~w_empty;
         if (!w_rd)                    rdata <= '0;
         else if (r_addr_s2 == A_STAT) rdata <= w_status;
         else if (w_empty)             rdata <= '0;
         else                          rdata <= w_head.code;
      end
   end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: a queue of expected entries is filled as
// key stimulus is driven and drained as the bench reads the bus.
module tb_key_event_queue;

   localparam int DEPTH = 8;
   localparam int RD    = 20;
   localparam int RR    = 5;
   localparam int CNTW  = 8;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       key_act  = 1'b0;
   logic       nCS      = 1'b1;
   logic       nRD      = 1'b1;
   logic       addr     = 1'b0;
   logic [7:0] rdata;
   logic       irq;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [8:0] exp_q[$];
   logic       m_ovf  = 1'b0;
   logic [7:0] m_held = 8'h00;
   logic [7:0] d;

   always #5 clk = ~clk;

   key_event_queue #(
      .DEPTH        (DEPTH),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR),
      .CNTW         (CNTW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .key_code (key_code),
      .key_act  (key_act),
      .nCS      (nCS),
      .nRD      (nRD),
      .addr     (addr),
      .rdata    (rdata),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic rel, input logic [7:0] code);
      if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else                       exp_q.push_back({rel, code});
   endtask

   function automatic logic [7:0] model_status();
      int   n;
      logic hrel;
      n    = exp_q.size();
      hrel = (n > 0) ? exp_q[0][8] : 1'b0;
      return {m_ovf, hrel, (n == DEPTH), (n == 0), 4'(n)};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic key_down(input logic [7:0] code);
      @(negedge clk);
      key_code = code;
      key_act  = 1'b1;
      m_held   = code;
      model_push(1'b0, code);
   endtask

   task automatic key_change(input logic [7:0] code);
      @(negedge clk);
      key_code = code;
      m_held   = code;
      model_push(1'b0, code);
   endtask

   task automatic key_up();
      @(negedge clk);
      key_act = 1'b0;
      model_push(1'b1, m_held);
   endtask

   task automatic bus_read(input logic a, output logic [7:0] v);
      @(negedge clk);
      addr = a;
      nCS  = 1'b0;
      nRD  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      v   = rdata;
      nRD = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      nCS = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pop_entry(input string tag);
      logic [7:0] v;
      logic [8:0] e;
      bus_read(1'b1, v);
      check({tag, " status"}, v, model_status());
      m_ovf = 1'b0;
      bus_read(1'b0, v);
      e = 9'h000;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check({tag, " data"}, v, e[7:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      check("reset irq", irq, 1'b0);
      check("reset rdata", rdata, 8'h00);
      cycles(3);
      @(negedge clk);
      reset = 1'b1;
      cycles(2);

      // Single press/release with press-to-irq latency
      key_down(8'd202);
      @(posedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("irq before N+3", irq, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("irq after N+3", irq, 1'b1);
      cycles(6);
      key_up();
      cycles(5);
      pop_entry("press202");
      pop_entry("rel202");
      check("irq after drain", irq, 1'b0);

      // Empty read
      bus_read(1'b0, d);
      check("empty data", d, 8'h00);
      bus_read(1'b1, d);
      check("empty status", d, 8'h10);

      // Auto-repeat: exactly 36 sampled-high cycles
      key_down(8'd86);
      for (int i = 0; i < 4; i++) model_push(1'b0, 8'd86);
      repeat (36) @(posedge clk);
      key_up();
      cycles(5);
      check("repeat count", exp_q.size(), 6);
      for (int i = 0; i < 6; i++) pop_entry($sformatf("rep%0d", i));

      // Key change while held
      key_down(8'd75);
      cycles(5);
      key_change(8'd232);
      cycles(5);
      key_up();
      cycles(5);
      for (int i = 0; i < 3; i++) pop_entry($sformatf("chg%0d", i));

      // Overflow: eight queued, further events dropped
      for (int i = 0; i < 4; i++) begin
         key_down(8'h10 + 8'(i));
         cycles(3);
         key_up();
         cycles(3);
      end
      key_down(8'h77);
      cycles(3);
      key_up();
      cycles(5);
      bus_read(1'b1, d);
      check("ovf status", d, 8'hA8);
      m_ovf = 1'b0;
      bus_read(1'b1, d);
      check("ovf cleared", d, 8'h28);
      for (int i = 0; i < 8; i++) pop_entry($sformatf("ovf%0d", i));
      check("ovf drained irq", irq, 1'b0);

      // Asynchronous reset while a key is held with three entries queued
      key_down(8'd55);
      model_push(1'b0, 8'd55);
      model_push(1'b0, 8'd55);
      cycles(30);
      check("pre-reset count", dut.w_count, exp_q.size());
      check("pre-reset irq", irq, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("async reset irq", irq, 1'b0);
      check("async reset rdata", rdata, 8'h00);
      check("async reset count", dut.w_count, 0);
      exp_q.delete();
      m_ovf = 1'b0;
      cycles(2);
      @(negedge clk);
      reset = 1'b1;
      model_push(1'b0, 8'd55);
      cycles(6);
      check("post-reset irq", irq, 1'b1);
      key_up();
      cycles(5);
      pop_entry("rst press");
      pop_entry("rst rel");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
